// File: rtl/pipeline_sequencer_pkg.sv
// Shared types for the pipeline sequencer: controller states, register index type,
// and the control-word patterns driven to the pipeline registers.
package pipeline_sequencer_pkg;

    localparam int REGBITS_W     = 5;
    localparam int DRAIN_DEFAULT = 2;

    typedef logic [REGBITS_W-1:0] regbits_t;

    typedef enum logic [2:0] {
        RUN,
        DWAIT,
        LDUSE,
        DRAIN,
        HALTED
    } seq_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic exmem_flush;
        logic memwb_en;
    } seq_ctrl_t;

    // Field order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en
    localparam seq_ctrl_t CTRL_HOLD     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam seq_ctrl_t CTRL_ADVANCE  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam seq_ctrl_t CTRL_DRAIN    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    localparam seq_ctrl_t CTRL_REDIRECT = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    localparam seq_ctrl_t CTRL_LDUSE    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam seq_ctrl_t CTRL_IMISS    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

endpackage

// File: rtl/pipeline_sequencer_lu_detect.sv
// Load-use comparator: flags an ID-stage read of a register that the load in EX
// has not produced yet. Register 0 never creates a dependency.
module lu_detect #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_dest,
    output logic             lu
);

    assign lu = ex_memread && (ex_dest != '0) &&
                ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush controller for the 5-stage pipeline: owns the PC and pipeline-register
// enables/flushes. Optional performance counters with PIPELINE_SEQUENCER_PERF_EN.
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int REG_W        = 5,
    parameter int DRAIN_CYCLES = DRAIN_DEFAULT
`ifdef PIPELINE_SEQUENCER_PERF_EN
    ,
    parameter int CNT_W        = 32
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmem_req,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             redirect,
    input  logic             halt_mem,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
`ifdef PIPELINE_SEQUENCER_PERF_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
`endif
    output logic             halted
);

    localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES - 1);

    seq_state_t        state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    seq_ctrl_t         ctrl;
    logic              lu;
    logic              mem_wait;
    logic              redirect_taken;

    lu_detect #(.REG_W(REG_W)) u_lu_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .ex_memread (ex_memread),
        .ex_dest    (ex_dest),
        .lu         (lu)
    );

    assign mem_wait = dmem_req && !dhit;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        ctrl           = CTRL_HOLD;
        state_d        = state_q;
        dcnt_d         = dcnt_q;
        redirect_taken = 1'b0;
        unique case (state_q)
            RUN, LDUSE, DWAIT: begin
                // DWAIT freezes everything; on dhit it falls through to the RUN rules.
                if (state_q == DWAIT && !dhit) begin
                    ctrl = CTRL_HOLD;
                end else if (halt_mem) begin
                    ctrl    = CTRL_DRAIN;
                    state_d = DRAIN;
                    dcnt_d  = DRAIN_LOAD;
                end else if (mem_wait) begin
                    state_d = DWAIT;
                end else if (redirect) begin
                    ctrl           = CTRL_REDIRECT;
                    state_d        = RUN;
                    redirect_taken = 1'b1;
                end else if (lu && state_q != LDUSE) begin
                    ctrl    = CTRL_LDUSE;
                    state_d = LDUSE;
                end else if (!ihit) begin
                    ctrl    = CTRL_IMISS;
                    state_d = RUN;
                end else begin
                    ctrl    = CTRL_ADVANCE;
                    state_d = RUN;
                end
            end
            DRAIN: begin
                ctrl = CTRL_DRAIN;
                if (dcnt_q == '0) begin
                    state_d = HALTED;
                end else begin
                    dcnt_d = dcnt_q - DCNT_W'(1);
                end
            end
            HALTED: begin
                ctrl = CTRL_HOLD;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Reset forces every control low regardless of the decoded state.
    assign {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
            exmem_en, exmem_flush, memwb_en} = RST ? CTRL_HOLD : ctrl;
    assign halted = !RST && (state_q == HALTED);

`ifdef PIPELINE_SEQUENCER_PERF_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!ctrl.pc_en && state_q != HALTED && stall_q != '1) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (redirect_taken && flush_q != '1) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed steps plus random stimulus,
// compared each cycle against an event-priority reference model.
module tb_pipeline_sequencer;

    localparam int REG_W        = 5;
    localparam int DRAIN_CYCLES = 2;

    // Bit order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en
    localparam logic [7:0] P_HOLD  = 8'b0000_0000;
    localparam logic [7:0] P_ALL   = 8'b1101_0101;
    localparam logic [7:0] P_DRAIN = 8'b0010_1011;
    localparam logic [7:0] P_REDIR = 8'b1010_1011;
    localparam logic [7:0] P_LDUSE = 8'b0000_1101;
    localparam logic [7:0] P_IMISS = 8'b0011_0101;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic ihit, dhit, dmem_req, id_uses_rt, ex_memread, redirect, halt_mem;
    logic [REG_W-1:0] id_rs, id_rt, ex_dest;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic exmem_en, exmem_flush, memwb_en, halted;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending data wait, bubble just inserted, drain cycles left, halted.
    bit m_wait, m_bubble, m_halted;
    int m_drain;

    pipeline_sequencer #(.REG_W(REG_W), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (ihit),
        .dhit        (dhit),
        .dmem_req    (dmem_req),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_memread  (ex_memread),
        .ex_dest     (ex_dest),
        .redirect    (redirect),
        .halt_mem    (halt_mem),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_en     (idex_en),
        .idex_flush  (idex_flush),
        .exmem_en    (exmem_en),
        .exmem_flush (exmem_flush),
        .memwb_en    (memwb_en),
        .halted      (halted)
    );

    initial forever #5 CLK = ~CLK;

    // A flushed register's enable is a don't-care.
    function automatic logic [7:0] care_mask(input logic [7:0] e);
        logic [7:0] m;
        m = 8'hFF;
        if (e[5]) m[6] = 1'b0;
        if (e[3]) m[4] = 1'b0;
        if (e[1]) m[2] = 1'b0;
        return m;
    endfunction

    task automatic model_step(output logic [7:0] e, output logic eh);
        bit lu_m;
        bit was_bubble;
        lu_m = ex_memread && (ex_dest != 0) &&
               ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));
        e  = P_HOLD;
        eh = 1'b0;
        if (RST) begin
            m_wait = 0; m_bubble = 0; m_halted = 0; m_drain = 0;
        end else if (m_halted) begin
            eh = 1'b1;
        end else if (m_drain > 0) begin
            e = P_DRAIN;
            m_drain--;
            if (m_drain == 0) m_halted = 1;
        end else if (m_wait && !dhit) begin
            e = P_HOLD;
        end else begin
            was_bubble = m_bubble;
            m_wait     = 0;
            m_bubble   = 0;
            if (halt_mem) begin
                e = P_DRAIN;
                m_drain = DRAIN_CYCLES;
            end else if (dmem_req && !dhit) begin
                m_wait = 1;
            end else if (redirect) begin
                e = P_REDIR;
            end else if (lu_m && !was_bubble) begin
                e = P_LDUSE;
                m_bubble = 1;
            end else if (!ihit) begin
                e = P_IMISS;
            end else begin
                e = P_ALL;
            end
        end
    endtask

    task automatic cycle(input string tag);
        logic [7:0] e, obs, mask;
        logic eh;
        @(negedge CLK);
        model_step(e, eh);
        obs  = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en};
        mask = care_mask(e);
        checks++;
        assert ((obs & mask) === (e & mask)) else begin
            failures++;
            $error("FAIL %s ctrl observed=%b expected=%b", tag, obs & mask, e & mask);
        end
        checks++;
        assert (halted === eh) else begin
            failures++;
            $error("FAIL %s halted observed=%b expected=%b", tag, halted, eh);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ihit = 1; dhit = 1; dmem_req = 0; id_uses_rt = 0; ex_memread = 0;
        redirect = 0; halt_mem = 0; id_rs = '0; id_rt = '0; ex_dest = '0;
    endtask

    task automatic randomize_inputs(input bit allow_halt);
        ihit       = ($urandom_range(0, 3) != 0);
        dhit       = $urandom_range(0, 1) != 0;
        dmem_req   = ($urandom_range(0, 2) == 0);
        redirect   = ($urandom_range(0, 5) == 0);
        halt_mem   = allow_halt && ($urandom_range(0, 3) == 0);
        ex_memread = $urandom_range(0, 1) != 0;
        id_uses_rt = $urandom_range(0, 1) != 0;
        id_rs      = REG_W'($urandom_range(0, 3));
        id_rt      = REG_W'($urandom_range(0, 3));
        ex_dest    = REG_W'($urandom_range(0, 3));
    endtask

    initial begin
        idle();
        RST = 1;
        repeat (2) cycle("reset");
        RST = 0;
        cycle("run_idle");

        // lw $3 in EX, add $4,$3,$5 in ID
        ex_memread = 1; ex_dest = 5'd3; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1;
        cycle("lu_c0");
        cycle("lu_c1");
        id_rs = 5'd7; id_rt = 5'd3;
        cycle("lu_rt");
        cycle("lu_rt_bubble");
        ex_dest = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        cycle("lu_r0");
        ex_dest = 5'd6; id_rs = 5'd1; id_rt = 5'd6; id_uses_rt = 0;
        cycle("lu_rt_unused");

        idle();
        dmem_req = 1; dhit = 0;
        repeat (3) cycle("dwait");
        dhit = 1;
        cycle("dwait_hit");
        idle();
        cycle("after_dwait");

        dmem_req = 1; dhit = 0;
        cycle("dwait2_enter");
        redirect = 1;
        cycle("dwait_redir_hold");
        dhit = 1;
        cycle("dwait_redir_act");
        idle();

        redirect = 1; ex_memread = 1; ex_dest = 5'd4; id_rs = 5'd4;
        cycle("redir_lu");
        redirect = 0;
        cycle("redir_lu_after");
        idle();
        ihit = 0;
        cycle("imiss");
        idle();

        // Asynchronous reset in the middle of a data wait
        dmem_req = 1; dhit = 0;
        cycle("pre_rst_wait");
        cycle("pre_rst_dwait");
        RST = 1;
        #1;
        checks++;
        assert ({pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
                 exmem_flush, memwb_en, halted} === 9'b0) else begin
            failures++;
            $error("FAIL rst_async observed=%b expected=%b",
                   {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
                    exmem_flush, memwb_en, halted}, 9'b0);
        end
        cycle("rst_dwait");
        RST = 0;
        idle();
        cycle("rst_release");

        repeat (400) begin
            randomize_inputs(1'b0);
            cycle("rand");
        end

        RST = 1;
        idle();
        cycle("reset2");
        RST = 0;
        halt_mem = 1; redirect = 1;
        cycle("halt_redir");
        halt_mem = 0; redirect = 0;
        repeat (DRAIN_CYCLES) cycle("drain");
        cycle("halted");
        repeat (30) begin
            randomize_inputs(1'b1);
            cycle("halted_sticky");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Owns every pipeline-register enable and flush, and the PC enable.
- Resolves these events: load-use interlock, instruction-fetch wait, data-memory wait, taken branch/jump redirect, and the halt drain sequence.
- Sits beside the forwarding logic: forwarding covers ALU-to-ALU dependencies, and this block covers everything forwarding cannot.

Parameters:
- REG_W, 5, register-index width.
- DRAIN_CYCLES, 2, cycles held in HALT_DRAIN before asserting halted (must be ≥1).
- CNT_W, 32, performance-counter width (used only with the optional feature).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset; asynchronous, active-high.
- ihit  in  1  instruction fetch completes this cycle.
- dhit  in  1  data access completes this cycle.
- dmem_req  in  1  MEM-stage instruction is a load or store.
- id_rs  in  REG_W  ID-stage source register rs.
- id_rt  in  REG_W  ID-stage source register rt.
- id_uses_rt  in  1  ID-stage instruction reads rt.
- ex_memread  in  1  EX-stage instruction is a load.
- ex_dest  in  REG_W  EX-stage destination register.
- redirect  in  1  MEM stage resolved a taken branch or jump.
- halt_mem  in  1  HALT opcode is in the MEM stage.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID register loads a NOP.
- idex_en  out  1  ID/EX register enable.
- idex_flush  out  1  ID/EX register loads a NOP.
- exmem_en  out  1  EX/MEM register enable.
- exmem_flush  out  1  EX/MEM register loads a NOP.
- memwb_en  out  1  MEM/WB register enable.
- halted  out  1  sticky halt indication.

Behaviour:
- Architecture: the state register and drain counter are sequential; outputs are a combinational function of state and inputs.
- A flush overrides the corresponding enable.
- States: RUN, DWAIT, LDUSE, DRAIN, HALTED.
- Reset (RST=1, asynchronous):
  - State goes to RUN and the drain counter clears.
  - While RST is high, all enables and flushes are 0 and halted is 0.
- Load-use hazard (lu) is defined as: ex_memread && ex_dest != 0 && (ex_dest == id_rs || (id_uses_rt && ex_dest == id_rt)).
- Priority within RUN, highest first: halt_mem, then memory wait (dmem_req && !dhit), then redirect, then lu, then !ihit.
- RUN, halt_mem:
  - Outputs: pc_en=0, ifid_flush=1, idex_flush=1, exmem_flush=1, memwb_en=1.
  - Next state DRAIN; counter loads DRAIN_CYCLES-1.
- RUN, memory wait:
  - All enables 0, no flushes.
  - Next state DWAIT.
- RUN, redirect:
  - Outputs: pc_en=1 (target load), ifid_flush=1, idex_flush=1, exmem_flush=1, memwb_en=1.
  - Next state RUN.
- RUN, lu:
  - Outputs: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1.
  - Next state LDUSE.
- RUN, !ihit:
  - Outputs: pc_en=0, ifid_flush=1; ID/EX, EX/MEM and MEM/WB advance.
- RUN, none of the above: all enables 1, no flushes.
- DWAIT:
  - All enables 0 until dhit.
  - On dhit, re-evaluate using the RUN rules in the same cycle, then return to RUN.
  - A redirect or halt_mem asserted while in DWAIT is held stable (EX/MEM is frozen) and acted on at the dhit cycle.
- LDUSE:
  - Exactly one bubble is inserted, so lu is ignored for this cycle.
  - Apply the RUN rules for the remaining events; next state RUN.
  - A memory wait in this cycle goes to DWAIT.
- DRAIN:
  - pc_en=0; IF/ID, ID/EX and EX/MEM are flushed; memwb_en=1.
  - Counter decrements each cycle; at 0 the next state is HALTED.
  - Redirect and lu are ignored.
- HALTED:
  - All enables 0 and halted=1 until RST.
- Simultaneous events:
  - redirect together with lu: redirect wins, because the flushed ID instruction removes the hazard.
  - halt_mem together with redirect: halt wins.
- Reset during DWAIT or DRAIN returns immediately to RUN with no residual stall.

Optional Feature:
- Macro: PIPELINE_SEQUENCER_PERF_EN.
- When defined:
  - Adds outputs stall_cycles (CNT_W) and flush_events (CNT_W), both cleared by RST.
  - stall_cycles increments on every cycle with pc_en=0 while not HALTED.
  - flush_events increments on each redirect acted on.
  - Both counters saturate at all-ones.
- When undefined: these ports and registers are absent, with no other behavioural change.

Decomposition:
- cpu_types_pkg gains:
  - the seq_state_t enum (RUN, DWAIT, LDUSE, DRAIN, HALTED);
  - a regbits_t-style REG_W typedef;
  - the DRAIN_DEFAULT constant.
- Interface file pipeline_sequencer_if.vh carries all non-clock ports.
- One natural sub-module, lu_detect: the combinational load-use comparator.

Test Plan:
- Load-use: lw $3 in EX, add $4,$3,$5 in ID:
  - Cycle 0: pc_en=0, ifid_en=0, idex_flush=1.
  - Cycle 1: all enables 1.
- ex_dest=0 with ex_memread=1 and id_rs=0 → no stall; all enables 1.
- dmem_req=1, dhit=0 for 3 cycles → all enables 0 for 3 cycles; on dhit, all enables 1 in that cycle.
- redirect=1 with lu true → pc_en=1 and ifid/idex/exmem flushes=1; no LDUSE entry.
- halt_mem=1 with DRAIN_CYCLES=2 → 2 DRAIN cycles with memwb_en=1, then halted=1; halted stays 1 under further stimulus.
- RST pulsed mid-DWAIT → outputs immediately 0; after release, state RUN with full enables. With PERF_EN, counters read 0.
